// File: rtl/z80_pkg.sv
// ----------------------------------------------------------------------------
// z80_pkg -- shared definitions for the Z80 bus monitor.
//   rec_type_e : 3-bit record type codes (6 and 7 are reserved, never emitted)
//   rec_t      : one 27-bit record {type, address, data}
//   classify() : maps registered strobes of an active bus cycle to a type code
// ----------------------------------------------------------------------------
package z80_pkg;

  typedef enum logic [2:0] {
    REC_FETCH  = 3'd0,
    REC_MEMRD  = 3'd1,
    REC_MEMWR  = 3'd2,
    REC_IORD   = 3'd3,
    REC_IOWR   = 3'd4,
    REC_INTACK = 3'd5
  } rec_type_e;

  localparam int REC_W = 27;

  typedef struct packed {
    rec_type_e   typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } rec_t;

  // Only meaningful while the cycle is active. With iorq_n high the cycle is a
  // memory access (mreq_n low is implied by the active decode), so mreq_n and
  // rd_n never change the outcome and are not arguments.
  function automatic rec_type_e classify(input logic iorq_n,
                                         input logic wr_n,
                                         input logic m1_n);
    if (!iorq_n && !m1_n)      return REC_INTACK;
    else if (!iorq_n && !wr_n) return REC_IOWR;
    else if (!iorq_n)          return REC_IORD;
    else if (!wr_n)            return REC_MEMWR;
    else if (!m1_n)            return REC_FETCH;
    else                       return REC_MEMRD;
  endfunction

endpackage

// File: rtl/z80_busmon_fifo.sv
// ----------------------------------------------------------------------------
// z80_busmon_fifo -- synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush, wins over push and pop
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : remove head (ignored when empty)
//   dout       : current head, valid whenever empty is low
//   full/empty : occupancy flags, derived from an internal count register
// ----------------------------------------------------------------------------
module z80_busmon_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // NOTE: storage has no reset; pointers and count define what is valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally at AW bits.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/z80_busmon.sv
// ----------------------------------------------------------------------------
// z80_busmon -- passive Z80 bus monitor producing one record per bus cycle.
//   Parameter FIFO_DEPTH : record FIFO depth, power of two, 2..256
//   clk, rst_n           : core clock, asynchronous active-low reset
//   a, d                 : address / data bus (observed only)
//   mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n : bus strobes
//   clr                  : synchronous flush of FIFO, ovf and drop_cnt
//   wait_n               : stall request to the core
//   rec_valid/rec_ready  : record stream handshake (FWFT head)
//   rec_type/addr/data   : record contents
//   ovf, drop_cnt        : sticky overflow flag, saturating drop counter
// Build option Z80_BUSMON_WAIT_EN: stall the core with wait_n instead of
// dropping records when the FIFO is full.
// ----------------------------------------------------------------------------
module z80_busmon
  import z80_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  input  logic        clr,
  output logic        wait_n,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_type,
  output logic [15:0] rec_addr,
  output logic [7:0]  rec_data,
  output logic        ovf,
  output logic [7:0]  drop_cnt
);

  logic [15:0] s_a;
  logic [7:0]  s_d;
  logic        s_mreq_n, s_iorq_n, s_rd_n, s_wr_n, s_m1_n, s_rfsh_n;
  logic        active;
  logic        active_d;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  rec_t        hold;
  rec_t        head;
  logic [REC_W-1:0] fifo_dout;

  // Strobes reset to their idle (high) level so nothing decodes as active
  // until real samples arrive after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a      <= '0;
      s_d      <= '0;
      s_mreq_n <= 1'b1;
      s_iorq_n <= 1'b1;
      s_rd_n   <= 1'b1;
      s_wr_n   <= 1'b1;
      s_m1_n   <= 1'b1;
      s_rfsh_n <= 1'b1;
    end else begin
      s_a      <= a;
      s_d      <= d;
      s_mreq_n <= mreq_n;
      s_iorq_n <= iorq_n;
      s_rd_n   <= rd_n;
      s_wr_n   <= wr_n;
      s_m1_n   <= m1_n;
      s_rfsh_n <= rfsh_n;
    end
  end

  // Refresh keeps mreq_n low but is excluded; INTACK is iorq_n with m1_n.
  assign active = (!s_mreq_n && s_rfsh_n && (!s_rd_n || !s_wr_n)) ||
                  (!s_iorq_n && (!s_rd_n || !s_wr_n || !s_m1_n));

  // Hold registers track every active sample, so the record carries the last
  // one before the strobes deassert (read data settles late in the cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_d <= 1'b0;
      hold     <= '0;
    end else begin
      active_d <= active;
      if (active) hold <= '{typ: classify(s_iorq_n, s_wr_n, s_m1_n),
                            addr: s_a, data: s_d};
    end
  end

  assign push = active_d & ~active;
  assign pop  = rec_valid & rec_ready;

  z80_busmon_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .din   (hold),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign head      = rec_t'(fifo_dout);
  assign rec_valid = ~empty;
  assign rec_type  = head.typ;
  assign rec_addr  = head.addr;
  assign rec_data  = head.data;

`ifdef Z80_BUSMON_WAIT_EN
  // Stall while a cycle is in progress and there is no room for its record;
  // the pop edge clears full, so the release follows one cycle after a pop.
  assign wait_n   = ~(active & full);
  assign ovf      = 1'b0;
  assign drop_cnt = '0;
`else
  logic       drop;
  logic       ovf_q;
  logic [7:0] drop_cnt_q;

  assign wait_n = 1'b1;
  // A simultaneous pop makes room, and clr discards the push anyway.
  assign drop   = push & full & ~pop & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
